// File: rtl/instr_fetch_unit.sv
// PC register and single-word instruction fetch over a wait-state handshake into the IR.
// Define FETCH_TIMEOUT_EN to abort fetches that are never acknowledged and flag FETCH_ERR.
module instr_fetch_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PC_CLR,
  input  logic               PC_LD,
  input  logic               PC_IC,
  input  logic [7:0]         PC_OFF,
  input  logic               FETCH_REQ,
  output logic [PC_W-1:0]    IM_ADDR,
  output logic               IM_RD,
  input  logic [INSTR_W-1:0] IM_RDATA,
  input  logic               IM_ACK,
  output logic [INSTR_W-1:0] IR,
  output logic               IR_VALID,
  output logic               BUSY,
  output logic [PC_W-1:0]    PC,
  output logic               FETCH_ERR
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // Offset is sign-extended to at least PC_W bits before the modular add.
  localparam int unsigned OffW = (PC_W > 8) ? PC_W : 8;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [OffW-1:0]    off_ext;
  logic               abort;

  assign off_ext = OffW'($signed(PC_OFF));

  always_comb begin
    pc_d = pc_q;
    if (PC_CLR) begin
      pc_d = '0;
    end else if (PC_LD) begin
      pc_d = pc_q + off_ext[PC_W-1:0];
    end else if (PC_IC) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Abort on the edge that completes the TIMEOUT-th WAIT cycle; an ACK on that edge wins.
  assign abort = (state_q == StWait) && !IM_ACK && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIdle && FETCH_REQ) begin
      cnt_d = '0;
    end else if (state_q == StWait && !IM_ACK) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (PC_CLR || (state_q == StIdle && FETCH_REQ)) begin
      err_d = 1'b0;
    end
    if (abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign FETCH_ERR = err_q;
`else
  assign abort     = 1'b0;
  assign FETCH_ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (FETCH_REQ) begin
          addr_d  = pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (IM_ACK) begin
          ir_d    = IM_RDATA;
          valid_d = 1'b1;
          state_d = StIdle;
        end else if (abort) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign PC       = pc_q;
  assign IM_ADDR  = addr_q;
  assign IM_RD    = (state_q == StWait);
  assign BUSY     = (state_q == StWait);
  assign IR       = ir_q;
  assign IR_VALID = valid_q;

  a_timeout_nonzero: assert property (@(posedge CLK) TIMEOUT != 0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a cycle-level behavioural model compared every cycle,
// plus directed literal checks for PC arithmetic, fetch timing, timeout and async reset.
module tb_instr_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 15;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               PC_CLR, PC_LD, PC_IC, FETCH_REQ, IM_ACK;
  logic [7:0]         PC_OFF;
  logic [INSTR_W-1:0] IM_RDATA;
  logic [PC_W-1:0]    IM_ADDR, PC;
  logic [INSTR_W-1:0] IR;
  logic               IM_RD, IR_VALID, BUSY, FETCH_ERR;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PC_CLR    (PC_CLR),
    .PC_LD     (PC_LD),
    .PC_IC     (PC_IC),
    .PC_OFF    (PC_OFF),
    .FETCH_REQ (FETCH_REQ),
    .IM_ADDR   (IM_ADDR),
    .IM_RD     (IM_RD),
    .IM_RDATA  (IM_RDATA),
    .IM_ACK    (IM_ACK),
    .IR        (IR),
    .IR_VALID  (IR_VALID),
    .BUSY      (BUSY),
    .PC        (PC),
    .FETCH_ERR (FETCH_ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: fetch in progress plus number of WAIT cycles elapsed.
  int m_pc, m_addr, m_ir, m_waited, old_pc, off;
  bit m_valid, m_busy, m_err;
  bit m_on = 1'b0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_pc = 0; m_addr = 0; m_ir = 0; m_waited = 0;
      m_valid = 0; m_busy = 0; m_err = 0;
    end else begin
      old_pc = m_pc;
      off = (PC_OFF >= 8'd128) ? int'(PC_OFF) - 256 : int'(PC_OFF);
      if (PC_CLR) m_pc = 0;
      else if (PC_LD) m_pc = (m_pc + off + 256) % 256;
      else if (PC_IC) m_pc = (m_pc + 1) % 256;
      m_valid = 0;
      if (PC_CLR) m_err = 0;
      if (m_busy) begin
        if (IM_ACK) begin
          m_ir = int'(IM_RDATA); m_valid = 1; m_busy = 0;
        end else begin
          m_waited++;
`ifdef FETCH_TIMEOUT_EN
          if (m_waited == TIMEOUT) begin
            m_busy = 0; m_err = 1;
          end
`endif
        end
      end else if (FETCH_REQ) begin
        m_addr = old_pc; m_busy = 1; m_waited = 0; m_err = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_on && !RESET) begin
      check("m_pc", PC, m_pc);
      check("m_im_addr", IM_ADDR, m_addr);
      check("m_im_rd", IM_RD, m_busy);
      check("m_busy", BUSY, m_busy);
      check("m_ir", IR, m_ir);
      check("m_ir_valid", IR_VALID, m_valid);
      check("m_fetch_err", FETCH_ERR, m_err);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    PC_CLR = 0; PC_LD = 0; PC_IC = 0; FETCH_REQ = 0; IM_ACK = 0;
  endtask

  int rd_cnt;
  int ack_pct;

  initial begin
    RESET = 1'b1;
    quiet();
    PC_OFF = 8'h00;
    IM_RDATA = '0;
    repeat (2) cyc();
    check("rst_pc", PC, 0);
    check("rst_ir", IR, 0);
    check("rst_addr", IM_ADDR, 0);
    check("rst_im_rd", IM_RD, 0);
    check("rst_valid", IR_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", FETCH_ERR, 0);
    RESET = 1'b0;
    m_on = 1'b1;

    // PC arithmetic and priority
    PC_IC = 1; repeat (3) cyc(); PC_IC = 0;
    check("pc_inc3", PC, 8'h03);
    PC_LD = 1; PC_OFF = 8'hFC; cyc(); PC_LD = 0;
    check("pc_ld_ff", PC, 8'hFF);
    PC_IC = 1; cyc(); PC_IC = 0;
    check("pc_wrap", PC, 8'h00);
    PC_LD = 1; PC_OFF = 8'h10; cyc();
    check("pc_ld_10", PC, 8'h10);
    PC_OFF = 8'hFC; cyc(); PC_LD = 0;
    check("pc_ld_neg", PC, 8'h0C);
    PC_CLR = 1; PC_LD = 1; PC_IC = 1; PC_OFF = 8'h33; cyc(); quiet();
    check("pc_prio", PC, 8'h00);
    PC_LD = 1; PC_OFF = 8'h05; cyc(); PC_LD = 0;
    check("pc_5", PC, 8'h05);

    // Wait-state fetch with address freeze and ignored FETCH_REQ
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    rd_cnt = 0;
    if (IM_RD) rd_cnt++;
    check("f_addr0", IM_ADDR, 8'h05);
    check("f_busy0", BUSY, 1);
    PC_IC = 1; cyc();
    if (IM_RD) rd_cnt++;
    check("f_pc6", PC, 8'h06);
    FETCH_REQ = 1; cyc(); PC_IC = 0; FETCH_REQ = 0;
    if (IM_RD) rd_cnt++;
    check("f_pc7", PC, 8'h07);
    check("f_addr_frozen", IM_ADDR, 8'h05);
    IM_ACK = 1; IM_RDATA = 16'h1234; cyc(); IM_ACK = 0;
    if (IM_RD) rd_cnt++;
    check("f_ir", IR, 16'h1234);
    check("f_valid", IR_VALID, 1);
    check("f_busy_drop", BUSY, 0);
    check("f_pc_after", PC, 8'h07);
    cyc();
    check("f_valid_pulse", IR_VALID, 0);
    check("f_req_ignored", IM_RD, 0);
    check("f_im_rd_cycles", rd_cnt, 3);

`ifdef FETCH_TIMEOUT_EN
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    rd_cnt = 0;
    for (int i = 0; i < 40 && IM_RD; i++) begin
      rd_cnt++;
      cyc();
    end
    check("to_cycles", rd_cnt, TIMEOUT);
    check("to_err", FETCH_ERR, 1);
    check("to_ir_kept", IR, 16'h1234);
    check("to_no_valid", IR_VALID, 0);
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    check("to_err_clr_req", FETCH_ERR, 0);
    check("to_refetch", IM_RD, 1);
    IM_ACK = 1; IM_RDATA = 16'h4321; cyc(); IM_ACK = 0;
    check("to_refetch_ir", IR, 16'h4321);
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    repeat (TIMEOUT) cyc();
    check("to_err2", FETCH_ERR, 1);
    PC_CLR = 1; cyc(); PC_CLR = 0;
    check("to_err_clr_pc", FETCH_ERR, 0);
`else
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    rd_cnt = 0;
    repeat (100) begin
      if (IM_RD && !FETCH_ERR) rd_cnt++;
      cyc();
    end
    check("nto_rd_held", rd_cnt, 100);
    check("nto_err", FETCH_ERR, 0);
    IM_ACK = 1; IM_RDATA = 16'h4321; cyc(); IM_ACK = 0;
    check("nto_ir", IR, 16'h4321);
`endif

    // Randomized traffic with varying acknowledge rates
    for (int blk = 0; blk < 8; blk++) begin
      ack_pct = (blk % 4 == 0) ? 60 : (blk % 4 == 1) ? 25 : (blk % 4 == 2) ? 4 : 12;
      repeat (500) begin
        PC_CLR    = ($urandom_range(0, 31) == 0);
        PC_LD     = ($urandom_range(0, 4) == 0);
        PC_IC     = ($urandom_range(0, 2) == 0);
        PC_OFF    = 8'($urandom);
        FETCH_REQ = ($urandom_range(0, 1) == 1);
        IM_ACK    = ($urandom_range(0, 99) < ack_pct);
        IM_RDATA  = 16'($urandom);
        cyc();
      end
    end
    quiet();
    IM_ACK = 1; cyc(); IM_ACK = 0;

    // Asynchronous reset in the middle of a fetch
    PC_CLR = 1; cyc(); PC_CLR = 0;
    PC_LD = 1; PC_OFF = 8'h22; cyc(); PC_LD = 0;
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    IM_ACK = 1; IM_RDATA = 16'hA5A5; cyc(); IM_ACK = 0;
    check("r_ir_pre", IR, 16'hA5A5);
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    check("r_in_wait", IM_RD, 1);
    #2 RESET = 1'b1;
    #1;
    check("r_im_rd", IM_RD, 0);
    check("r_ir", IR, 0);
    check("r_pc", PC, 0);
    check("r_busy", BUSY, 0);
    check("r_addr", IM_ADDR, 0);
    RESET = 1'b0;
    IM_ACK = 1; IM_RDATA = 16'hBEEF; cyc(); IM_ACK = 0;
    check("r_late_ack_ir", IR, 0);
    check("r_late_ack_valid", IR_VALID, 0);
    check("r_late_ack_rd", IM_RD, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
